vec_reg_streamer: RTL
=====================

# vec_reg_streamer

Read-side sequencer for the vector register file: on a start request it reads one register group (base register, LMUL 1/2/4/8) through the file's asynchronous read port. It captures the group in a single cycle and serializes it as narrow valid/ready beats toward the vector store / memory path. It sits between the issue logic and the store data path. It is the reader counterpart to the writeback logic that fills `vec_regfile`.

## Interface
- `VLEN`, 512, bits per architectural vector register
- `MAX_VLEN`, 4096, regfile data port width (8×VLEN)
- `ADDR_WIDTH`, 32, regfile address width
- `BEAT_WIDTH`, 32, output beat width; VLEN must be a multiple of it
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-low reset
- `start_valid`  in  1  stream request
- `start_ready`  out  1  high only in IDLE
- `vs_addr`  in  5  base vector register of the group
- `lmul`  in  4  group size; legal values are 1, 2, 4 and 8
- `rf_raddr`  out  ADDR_WIDTH  to regfile `raddr_1`
- `rf_lmul`  out  4  to regfile `lmul`
- `rf_rdata`  in  MAX_VLEN  from regfile `rdata_1`, combinational
- `rf_wrong_addr`  in  1  from regfile `wrong_addr`
- `beat_data`  out  BEAT_WIDTH  current beat
- `beat_valid`  out  1  beat available
- `beat_ready`  in  1  consumer accepts beat
- `beat_last`  out  1  final beat of group, qualified by `beat_valid`
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse after the last beat handshake
- `err`  out  1  one-cycle pulse on a rejected request

## Operation
- States: IDLE, FETCH, STREAM.
- **IDLE**
  - `start_ready`=1, `rf_raddr`=0, `rf_lmul`=1.
  - On `start_valid & start_ready`, latch `vs_addr` and `lmul`, then check legality:
    - `lmul` ∈ {1,2,4,8};
    - `vs_addr % lmul == 0`;
    - `vs_addr + lmul ≤ 32`.
  - Illegal request: `err` pulses next cycle and the state stays IDLE.
  - Legal request: go to FETCH.
- **FETCH** (exactly 1 cycle)
  - Drive `rf_raddr`=base and `rf_lmul`=latched lmul.
  - If `rf_wrong_addr`=1: go to IDLE, `err` pulses next cycle, buffer is not loaded.
  - Otherwise:
    - Load the buffer with `rf_rdata[lmul*VLEN-1:0]`; upper buffer bits are 0.
    - Load the beat counter with total = lmul*VLEN/BEAT_WIDTH (16/32/64/128 at defaults).
    - Go to STREAM.
- **STREAM**
  - `beat_valid`=1 and `beat_data`=buffer[BEAT_WIDTH-1:0]; beat order is LSB first.
  - On a handshake, shift the buffer right by BEAT_WIDTH and decrement the counter.
  - `beat_last`=1 when counter==1.
  - On the handshake of the last beat, go to IDLE; `done`=1 in the following cycle.
- Handshake rules:
  - While `beat_valid & !beat_ready`, `beat_data` and `beat_last` hold stable.
  - `beat_valid` never drops before its handshake.
- `start_valid` outside IDLE is ignored; the request is neither latched nor errored.
- Counter width is clog2(MAX_VLEN/BEAT_WIDTH)+1; it never wraps.
- Reset:
  - `reset`=0 at any clock edge → next state IDLE.
  - Buffer and counter cleared.
  - `beat_valid`, `beat_last`, `done`, `err` and `busy` = 0.
  - `start_ready`=1 after the reset edge.
  - A reset during STREAM aborts the group with no `beat_last` and no `done`.

## Timing
- Request accepted at edge N:
  - FETCH spans N→N+1, with `rf_raddr` valid combinationally in that cycle.
  - First `beat_valid` appears in the cycle after edge N+1.
- With `beat_ready` held at 1, beats are back-to-back, one per cycle.
  - lmul=1 → beats occupy 16 cycles, last handshake at edge N+17, `done` high in cycle N+17→N+18, `start_ready` high again in the same cycle.
- Latency from start to first beat is 2 cycles.
- Throughput is 1 beat/cycle; a group takes total+2 cycles including FETCH.
- `err` appears 1 cycle after the accept (illegal parameters) or after FETCH (`rf_wrong_addr`).
- `rf_raddr` and `rf_lmul` are decoded from registered state and latched fields, never from `start_*` inputs.

## Test plan
- lmul=1, vs_addr=3; v3 word k = k (k=0..15); `beat_ready`=1 → 16 beats with data 0..15, `beat_last` on data 15, `done` 1 cycle later, `rf_raddr`=3 only in FETCH.
- lmul=8, vs_addr=8; v8..v15 filled with an incrementing 32-bit pattern from 0x100; `beat_ready` toggling 1/0 → 128 beats 0x100..0x17F in order, data stable on stalled cycles, `beat_last` only on 0x17F.
- lmul=4, vs_addr=6 (misaligned) → `err`=1 one cycle after accept, `beat_valid` never set, `rf_raddr` stays 0; lmul=3 gives the same result.
- lmul=2, vs_addr=4 with `rf_wrong_addr` forced 1 during FETCH → `err` pulse, no beats, `start_ready`=1 on the next cycle.
- lmul=2 stream; `reset`=0 on the edge after beat 5 handshake → `beat_valid`=0 and `busy`=0 next cycle; a new lmul=2 request then streams from beat 0 with fresh data.
- `start_valid` held high throughout an lmul=1 stream with a different `vs_addr` → exactly one group streamed and no `err`; the second request is accepted only once IDLE is reached.

Source files
------------

// File: rtl/vec_reg_streamer.sv
// Reads one vector register group from the regfile in a single FETCH cycle,
// then streams it LSB-first as BEAT_WIDTH valid/ready beats.
module vec_reg_streamer #(
    parameter int VLEN       = 512,
    parameter int MAX_VLEN   = 4096,
    parameter int ADDR_WIDTH = 32,
    parameter int BEAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [4:0]            vs_addr,
    input  logic [3:0]            lmul,
    output logic [ADDR_WIDTH-1:0] rf_raddr,
    output logic [3:0]            rf_lmul,
    input  logic [MAX_VLEN-1:0]   rf_rdata,
    input  logic                  rf_wrong_addr,
    output logic [BEAT_WIDTH-1:0] beat_data,
    output logic                  beat_valid,
    input  logic                  beat_ready,
    output logic                  beat_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int NREG  = MAX_VLEN / VLEN;
    localparam int BPR   = VLEN / BEAT_WIDTH;
    localparam int CNT_W = $clog2(MAX_VLEN / BEAT_WIDTH) + 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FETCH  = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;

    logic [1:0]          state;
    logic [4:0]          base;
    logic [3:0]          grp;
    logic [MAX_VLEN-1:0] data_buf;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    total;
    logic                done_q;
    logic                err_q;

    logic       lmul_ok;
    logic       aligned;
    logic       in_range;
    logic       legal;
    logic [3:0] lmul_m1;
    logic [5:0] end_reg;

    // Group must be a power-of-two size, naturally aligned and inside v0..v31.
    assign lmul_ok  = (lmul == 4'd1) || (lmul == 4'd2) || (lmul == 4'd4) || (lmul == 4'd8);
    assign lmul_m1  = lmul - 4'd1;
    assign aligned  = (vs_addr[3:0] & lmul_m1) == 4'd0;
    assign end_reg  = {1'b0, vs_addr} + {2'b00, lmul};
    assign in_range = end_reg <= 6'd32;
    assign legal    = lmul_ok & aligned & in_range;

    assign total = CNT_W'(grp) * CNT_W'(BPR);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            base     <= '0;
            grp      <= '0;
            data_buf <= '0;
            cnt      <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        base <= vs_addr;
                        grp  <= lmul;
                        if (legal) state <= FETCH;
                        else       err_q <= 1'b1;
                    end
                end
                FETCH: begin
                    if (rf_wrong_addr) begin
                        state <= IDLE;
                        err_q <= 1'b1;
                    end else begin
                        // Registers past the group are zeroed so stale regfile data never leaks.
                        for (int i = 0; i < NREG; i++)
                            data_buf[i*VLEN +: VLEN] <= (i < int'(grp)) ? rf_rdata[i*VLEN +: VLEN] : '0;
                        cnt   <= total;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (beat_ready) begin
                        data_buf <= data_buf >> BEAT_WIDTH;
                        cnt      <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign start_ready = state == IDLE;
    assign busy        = state != IDLE;
    assign beat_valid  = state == STREAM;
    assign beat_last   = beat_valid && (cnt == CNT_W'(1));
    assign beat_data   = data_buf[BEAT_WIDTH-1:0];
    assign rf_raddr    = (state == FETCH) ? ADDR_WIDTH'(base) : '0;
    assign rf_lmul     = (state == FETCH) ? grp : 4'd1;
    assign done        = done_q;
    assign err         = err_q;

endmodule
